instruction_fetch_unit: RTL and testbench

- Requester side of the instruction-memory read interface: owns the program counter, drives the word-aligned fetch address and captures the returned instruction into the IF/ID pipeline register.
- Sits between control/branch resolution and the instruction memory.
- Supports start/halt sequencing, pipeline stall, flush and branch/jump redirect.
- The memory responds combinationally and uses Address[8:2], so the fetch unit always presents word-aligned addresses.

---
 rtl/instruction_fetch_unit.sv | 108 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives word-aligned fetch addresses to a
// combinational instruction memory and captures the returned word into IF/ID.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Halt,
  input  logic                   Stall,
  input  logic                   Flush,
  input  logic                   RedirectValid,
  input  logic [31:0]            RedirectTarget,
  output logic [31:0]            IMemAddress,
  input  logic [31:0]            IMemInstruction,
  output logic [31:0]            IFID_Instruction,
  output logic [31:0]            IFID_PCPlus4,
  output logic                   IFID_Valid,
  output logic [31:0]            PC,
  output logic [1:0]             State,
  output logic [COUNT_WIDTH-1:0] FetchCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t                 r_state,       w_state_next;
  logic [31:0]            r_pc,          w_pc_next;
  logic [31:0]            r_ifid_instr,  w_ifid_instr_next;
  logic [31:0]            r_ifid_pcp4,   w_ifid_pcp4_next;
  logic                   r_ifid_valid,  w_ifid_valid_next;
  logic [COUNT_WIDTH-1:0] r_fetch_count, w_fetch_count_next;

  logic [31:0] w_pc_plus4;
  assign w_pc_plus4 = r_pc + 32'd4;

  // NOTE: every signal written here gets a hold/default value first, so no
  // path through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_ifid_instr_next  = r_ifid_instr;
    w_ifid_pcp4_next   = r_ifid_pcp4;
    w_ifid_valid_next  = r_ifid_valid;
    w_fetch_count_next = r_fetch_count;

    case (r_state)
      S_IDLE: begin
        if (Halt)       w_state_next = S_HALT;
        else if (Start) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (Halt || RedirectValid || Flush) begin
          // Any of these squashes whatever would have entered IF/ID this cycle.
          w_ifid_instr_next = 32'd0;
          w_ifid_pcp4_next  = 32'd0;
          w_ifid_valid_next = 1'b0;
          if (Halt)               w_state_next = S_HALT;
          else if (RedirectValid) w_pc_next    = RedirectTarget & ALIGN_MASK;
        end else if (!Stall) begin
          w_ifid_instr_next = IMemInstruction;
          w_ifid_pcp4_next  = w_pc_plus4;
          w_ifid_valid_next = 1'b1;
          w_pc_next         = w_pc_plus4;
          if (!(&r_fetch_count))
            w_fetch_count_next = r_fetch_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      S_HALT: ;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC & ALIGN_MASK;
      r_ifid_instr  <= 32'd0;
      r_ifid_pcp4   <= 32'd0;
      r_ifid_valid  <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_ifid_instr  <= w_ifid_instr_next;
      r_ifid_pcp4   <= w_ifid_pcp4_next;
      r_ifid_valid  <= w_ifid_valid_next;
      r_fetch_count <= w_fetch_count_next;
    end
  end

  assign IMemAddress      = r_pc;
  assign PC               = r_pc;
  assign State            = r_state;
  assign IFID_Instruction = r_ifid_instr;
  assign IFID_PCPlus4     = r_ifid_pcp4;
  assign IFID_Valid       = r_ifid_valid;
  assign FetchCount       = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios with fixed
// expectations, then randomized control inputs checked against a cycle model.
module tb_instruction_fetch_unit;

  localparam int CW      = 5;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Reset, Start, Halt, Stall, Flush, RedirectValid;
  logic [31:0]   RedirectTarget;
  logic [31:0]   IMemAddress, IMemInstruction;
  logic [31:0]   IFID_Instruction, IFID_PCPlus4, PC;
  logic          IFID_Valid;
  logic [1:0]    State;
  logic [CW-1:0] FetchCount;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state, in plain integers.
  logic [31:0] m_pc, m_instr, m_pcp4;
  int          m_state, m_valid, m_cnt;

  instruction_fetch_unit #(.RESET_PC(32'h0), .COUNT_WIDTH(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
    .Flush(Flush), .RedirectValid(RedirectValid), .RedirectTarget(RedirectTarget),
    .IMemAddress(IMemAddress), .IMemInstruction(IMemInstruction),
    .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
    .IFID_Valid(IFID_Valid), .PC(PC), .State(State), .FetchCount(FetchCount)
  );

  always #5 Clk = ~Clk;

  // Memory contents: word i holds i*3, indexed by address bits [8:2].
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return ((addr & 32'h1FC) >> 2) * 32'd3;
  endfunction

  assign IMemInstruction = mem_word(IMemAddress);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fails++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic set_in(input logic rs, input logic sa, input logic ha, input logic sl,
                        input logic fl, input logic rv, input logic [31:0] tg);
    Reset = rs; Start = sa; Halt = ha; Stall = sl; Flush = fl;
    RedirectValid = rv; RedirectTarget = tg;
  endtask

  // Advance the model by one cycle from the inputs currently applied.
  task automatic model_step();
    if (Reset) begin
      m_state = 0; m_pc = 32'h0; m_instr = 0; m_pcp4 = 0; m_valid = 0; m_cnt = 0;
    end else if (m_state == 0) begin
      if (Halt) m_state = 2;
      else if (Start) m_state = 1;
    end else if (m_state == 1) begin
      if (Halt) begin
        m_state = 2; m_instr = 0; m_pcp4 = 0; m_valid = 0;
      end else if (RedirectValid) begin
        m_pc = (RedirectTarget / 4) * 4; m_instr = 0; m_pcp4 = 0; m_valid = 0;
      end else if (Flush) begin
        m_instr = 0; m_pcp4 = 0; m_valid = 0;
      end else if (!Stall) begin
        m_instr = mem_word(m_pc);
        m_pcp4  = m_pc + 32'd4;
        m_valid = 1;
        m_pc    = m_pc + 32'd4;
        m_cnt   = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    PC,                  m_pc);
    check({tag, ".addr"},  IMemAddress,         m_pc);
    check({tag, ".state"}, 32'(State),          32'(m_state));
    check({tag, ".instr"}, IFID_Instruction,    m_instr);
    check({tag, ".pcp4"},  IFID_PCPlus4,        m_pcp4);
    check({tag, ".valid"}, 32'(IFID_Valid),     32'(m_valid));
    check({tag, ".count"}, 32'(FetchCount),     32'(m_cnt));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge Clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 32'h0);
    cycle("reset");
    check("reset.pc_const", PC, 32'h0);
    check("reset.state_const", 32'(State), 32'h0);

    // Start cycle: enter RUN, nothing captured yet.
    set_in(0, 1, 0, 0, 0, 0, 32'h0);
    cycle("start");
    check("start.valid_const", 32'(IFID_Valid), 32'h0);
    set_in(0, 0, 0, 0, 0, 0, 32'h0);
    cycle("run1");
    check("run1.instr_const", IFID_Instruction, 32'd0);
    check("run1.pcp4_const", IFID_PCPlus4, 32'd4);
    check("run1.valid_const", 32'(IFID_Valid), 32'd1);
    cycle("run2");
    check("run2.instr_const", IFID_Instruction, 32'd3);
    check("run2.pc_const", PC, 32'h8);
    check("run2.count_const", 32'(FetchCount), 32'd2);
    cycle("run3");
    cycle("run4");
    check("run4.pc_const", PC, 32'h10);

    // Stall holds PC, IF/ID and the counter.
    set_in(0, 0, 0, 1, 0, 0, 32'h0);
    cycle("stall1");
    cycle("stall2");
    check("stall.pc_const", PC, 32'h10);
    check("stall.instr_const", IFID_Instruction, 32'd9);
    check("stall.count_const", 32'(FetchCount), 32'd4);
    set_in(0, 0, 0, 0, 0, 0, 32'h0);
    cycle("unstall");
    check("unstall.instr_const", IFID_Instruction, 32'd12);

    // Redirect to an unaligned target overrides Stall.
    set_in(0, 0, 0, 1, 0, 1, 32'h23);
    cycle("redir");
    check("redir.addr_const", IMemAddress, 32'h20);
    check("redir.valid_const", 32'(IFID_Valid), 32'd0);
    check("redir.instr_const", IFID_Instruction, 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 32'h0);
    cycle("redir_next");
    check("redir_next.instr_const", IFID_Instruction, 32'd24);

    // Flush at 0x0C refetches the same word.
    set_in(0, 0, 0, 0, 0, 1, 32'h0C);
    cycle("to_0c");
    set_in(0, 0, 0, 0, 1, 0, 32'h0);
    cycle("flush");
    check("flush.pc_const", PC, 32'h0C);
    check("flush.valid_const", 32'(IFID_Valid), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 32'h0);
    cycle("flush_next");
    check("flush_next.instr_const", IFID_Instruction, 32'd9);
    check("flush_next.pcp4_const", IFID_PCPlus4, 32'h10);

    // Halt is sticky; Start and Redirect ignored until Reset.
    set_in(0, 0, 1, 0, 0, 0, 32'h0);
    cycle("halt");
    check("halt.state_const", 32'(State), 32'h2);
    set_in(0, 1, 0, 0, 0, 1, 32'h40);
    cycle("halt_ign1");
    cycle("halt_ign2");
    check("halt_ign.pc_const", PC, 32'h10);
    set_in(1, 0, 0, 0, 0, 0, 32'h0);
    cycle("halt_reset");
    check("halt_reset.count_const", 32'(FetchCount), 32'd0);

    // PC+4 wraps at the top of the address space.
    set_in(0, 1, 0, 0, 0, 0, 32'h0);
    cycle("start2");
    set_in(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    cycle("redir_top");
    set_in(0, 0, 0, 0, 0, 0, 32'h0);
    cycle("wrap");
    check("wrap.pcp4_const", IFID_PCPlus4, 32'h0);
    check("wrap.pc_const", PC, 32'h0);

    // Reset in the middle of a stall.
    set_in(0, 0, 0, 1, 0, 0, 32'h0);
    cycle("stall_pre");
    set_in(1, 0, 0, 1, 0, 0, 32'h0);
    cycle("stall_reset");
    check("stall_reset.valid_const", 32'(IFID_Valid), 32'd0);

    // Counter saturation.
    set_in(0, 1, 0, 0, 0, 0, 32'h0);
    cycle("start3");
    set_in(0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < CNT_MAX + 8; i++) cycle("sat");
    check("sat.count_const", 32'(FetchCount), 32'(CNT_MAX));

    // Randomized control inputs.
    set_in(1, 0, 0, 0, 0, 0, 32'h0);
    cycle("rnd_reset");
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(99, 0) < 2,  $urandom_range(99, 0) < 30,
             $urandom_range(99, 0) < 3,  $urandom_range(99, 0) < 25,
             $urandom_range(99, 0) < 10, $urandom_range(99, 0) < 10,
             $urandom);
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
